// File: rtl/result_packer.sv
// rtl/result_packer.sv - rescale/clamp signed MAC results and pack LANES pixels per memory word
module result_packer #(
  parameter int ACC_W     = 20,
  parameter int PIX_W     = 8,
  parameter int LANES     = 4,
  parameter int SHIFT     = 4,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   res_valid,
  input  logic [ACC_W-1:0]       res_data,
  output logic                   res_ready,
  input  logic                   flush,
  output logic                   mem_wr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LANES*PIX_W-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done
);

  localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ACC_W-1:0]  PIX_MAX   = {{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [LC_W-1:0]   LAST_LANE = LC_W'(LANES-1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_FLUSH_WR = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]             state;
  logic [LC_W-1:0]        lane_cnt;
  logic [LANES*PIX_W-1:0] buffer;
  logic [ADDR_W-1:0]      addr;
  logic                   flush_pend;

  logic                   accept;
  logic [ACC_W-1:0]       q;
  logic [PIX_W-1:0]       pixel;
  logic [LANES*PIX_W-1:0] buf_ins;

  assign accept = res_valid & res_ready;
  assign q      = $signed(res_data) >>> SHIFT;

  // Negative results clamp to black, anything above the pixel range saturates.
  always_comb begin
    pixel = q[PIX_W-1:0];
    if (q[ACC_W-1]) begin
      pixel = '0;
    end else if (q > PIX_MAX) begin
      pixel = '1;
    end
  end

  always_comb begin
    buf_ins = buffer;
    for (int i = 0; i < LANES; i++) begin
      if (lane_cnt == LC_W'(i)) begin
        buf_ins[i*PIX_W +: PIX_W] = pixel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lane_cnt   <= '0;
      buffer     <= '0;
      addr       <= ADDR_BASE;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_COLLECT;
            lane_cnt   <= '0;
            buffer     <= '0;
            addr       <= ADDR_BASE;
            flush_pend <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            buffer   <= buf_ins;
            lane_cnt <= lane_cnt + 1'b1;
            if (lane_cnt == LAST_LANE) begin
              state      <= S_WRITE;
              flush_pend <= flush;
            end else if (flush) begin
              state <= S_FLUSH_WR;
            end
          end else if (flush) begin
            state <= (lane_cnt == '0) ? S_DONE : S_FLUSH_WR;
          end
        end
        S_WRITE: begin
          addr       <= addr + 1'b1;
          buffer     <= '0;
          lane_cnt   <= '0;
          flush_pend <= 1'b0;
          state      <= flush_pend ? S_DONE : S_COLLECT;
        end
        S_FLUSH_WR: begin
          addr     <= addr + 1'b1;
          buffer   <= '0;
          lane_cnt <= '0;
          state    <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registers only, so an asynchronous reset drops mem_wr at once.
  assign res_ready = (state == S_COLLECT);
  assign mem_wr    = (state == S_WRITE) || (state == S_FLUSH_WR);
  assign mem_addr  = addr;
  assign mem_wdata = mem_wr ? buffer : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
